// File: rtl/bus_mem_responder.sv
// Single-port word RAM bus target with a fixed access latency and registered handshake pulses.
// Optional byte-enable port when BUS_MEM_RESPONDER_STROBE_EN is defined.
module bus_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        read_req,
    input  logic        write_req,
`ifdef BUS_MEM_RESPONDER_STROBE_EN
    input  logic [3:0]  wstrb,
`endif
    output logic [31:0] rdata_out,
    output logic        bus_full,
    output logic        rdata_valid,
    output logic        wr_done,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 state;
    logic [3:0]             count;
    logic [ADDR_BITS-1:0]   word_q;
    logic [31:0]            wdata_q;
    logic [3:0]             strb_q;
    logic                   is_wr;
    logic                   bad_q;
    logic [3:0]             strb_in;
    logic                   req_bad;
    logic                   commit_wr;

    logic [31:0] mem [2**ADDR_BITS];

`ifdef BUS_MEM_RESPONDER_STROBE_EN
    assign strb_in = wstrb;
`else
    assign strb_in = 4'hF;
`endif

    // Misaligned, beyond the RAM, or a write that would touch no bytes.
    assign req_bad = (addr_in[1:0] != 2'b00) || ((addr_in >> (ADDR_BITS + 2)) != 32'd0)
                   || (write_req && strb_in == 4'h0);

    assign commit_wr = (state == S_WAIT) && (count == 4'd0) && is_wr && !bad_q;

    // LATENCY=1 spends its single latency cycle in WAIT with count already 0,
    // which keeps the response edge at acceptance+LATENCY for every legal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            count       <= 4'd0;
            word_q      <= '0;
            wdata_q     <= 32'd0;
            strb_q      <= 4'h0;
            is_wr       <= 1'b0;
            bad_q       <= 1'b0;
            rdata_out   <= 32'd0;
            bus_full    <= 1'b0;
            rdata_valid <= 1'b0;
            wr_done     <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            wr_done     <= 1'b0;
            err         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (read_req && write_req) begin
                        err <= 1'b1;
                    end else if (read_req || write_req) begin
                        word_q   <= addr_in[ADDR_BITS+1:2];
                        wdata_q  <= wdata_in;
                        strb_q   <= strb_in;
                        is_wr    <= write_req;
                        bad_q    <= req_bad;
                        count    <= 4'(LATENCY - 1);
                        bus_full <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count == 4'd0) begin
                        state <= S_RESP;
                        if (bad_q) begin
                            err <= 1'b1;
                        end else if (is_wr) begin
                            wr_done <= 1'b1;
                        end else begin
                            rdata_valid <= 1'b1;
                            rdata_out   <= mem[word_q];
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_RESP: begin
                    bus_full <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed table, corner sequences, random traffic.
module tb_bus_mem_responder;
    localparam int AB  = 8;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic [3:0]  wstrb = 4'hF;
    logic [31:0] rdata_out;
    logic        bus_full, rdata_valid, wr_done, err;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] ref_mem [2**AB];
    logic [31:0] ref_rdata = 32'd0;

    bus_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
        .read_req(read_req), .write_req(write_req),
`ifdef BUS_MEM_RESPONDER_STROBE_EN
        .wstrb(wstrb),
`endif
        .rdata_out(rdata_out), .bus_full(bus_full), .rdata_valid(rdata_valid),
        .wr_done(wr_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // One request from IDLE; checks every cycle of the handshake against the reference.
    // Called right after a falling edge; returns right after a falling edge with the DUT idle.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit corrupt, output bit saw_err);
        logic [3:0] s_eff;
        bit         bad;
        int         w;
`ifdef BUS_MEM_RESPONDER_STROBE_EN
        s_eff = s;
`else
        s_eff = 4'hF;
`endif
        bad = (a % 4 != 0) || (a >= 32'(4 * (2**AB))) || (wr && s_eff == 4'h0);
        w   = int'((a / 4) % (2**AB));
        read_req = rd; write_req = wr; addr_in = a; wdata_in = d; wstrb = s;
        saw_err = 1'b0;
        for (int j = 0; j <= LAT + 1; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == LAT && rd && !bad) ref_rdata = ref_mem[w];
            chk("bus_full", 32'(bus_full), 32'(j <= LAT));
            chk("rdata_valid", 32'(rdata_valid), 32'(j == LAT && rd && !bad));
            chk("wr_done", 32'(wr_done), 32'(j == LAT && wr && !bad));
            chk("err", 32'(err), 32'(j == LAT && bad));
            chk("rdata_out", rdata_out, ref_rdata);
            if (j == LAT) begin
                saw_err = err;
                read_req = 1'b0; write_req = 1'b0;
            end
            if (j == 0 && corrupt) begin
                addr_in = ~a; wdata_in = ~d; wstrb = ~s;
            end
        end
        if (wr && !bad)
            for (int b = 0; b < 4; b++)
                if (s_eff[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit          e;
        logic [31:0] a;
        bit          r;

        tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0402, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0011, 32'h5555_5555, 1'b1, 32'hCAFE_F00D};
        tbl[7] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};

        // Reset held with a read request pending: everything stays quiet.
        read_req = 1'b1;
        addr_in  = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_bus_full", 32'(bus_full), 32'd0);
            chk("rst_rdata", rdata_out, 32'd0);
            chk("rst_pulses", {29'd0, rdata_valid, wr_done, err}, 32'd0);
        end
        read_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Give every word a known value so reads are fully predictable.
        for (int i = 0; i < 2**AB; i++) txn(0, 1, 32'(i * 4), $urandom, 4'hF, 0, e);

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 4'hF, 0, e);
            chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
            chk("tbl_rdata", rdata_out, tbl[i].exp_rdata);
        end

        // Both requests at once: rejected every cycle, never busy.
        read_req = 1'b1; write_req = 1'b1; addr_in = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("both_err", 32'(err), 32'd1);
            chk("both_busy", 32'(bus_full), 32'd0);
            chk("both_rdata", rdata_out, ref_rdata);
        end
        read_req = 1'b0; write_req = 1'b0;
        @(negedge clk);
        chk("both_err_clr", 32'(err), 32'd0);

        // Inputs scrambled while busy must not reach the RAM.
        txn(0, 1, 32'h30, 32'hA5A5_0F0F, 4'hF, 1, e);
        txn(1, 0, 32'h30, 32'h0, 4'hF, 0, e);
        chk("busy_rdata", rdata_out, 32'hA5A5_0F0F);

        // Reset during WAIT drops the pending write.
        a = ref_mem[8];
        read_req = 1'b0; write_req = 1'b1; addr_in = 32'h20; wdata_in = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus_full), 32'd1);
        rst = 1'b0;
        write_req = 1'b0;
        #1;
        chk("abort_busy_rst", 32'(bus_full), 32'd0);
        chk("abort_rdata_rst", rdata_out, 32'd0);
        ref_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_pulses", {29'd0, rdata_valid, wr_done, err}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle_pulses", {29'd0, rdata_valid, wr_done, err}, 32'd0);
        txn(1, 0, 32'h20, 32'h0, 4'hF, 0, e);
        chk("abort_old_data", rdata_out, a);

`ifdef BUS_MEM_RESPONDER_STROBE_EN
        txn(0, 1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, e);
        txn(0, 1, 32'h40, 32'h0000_0000, 4'b0101, 0, e);
        txn(1, 0, 32'h40, 32'h0, 4'hF, 0, e);
        chk("strb_merge", rdata_out, 32'hFF00_FF00);
        txn(0, 1, 32'h40, 32'h1111_1111, 4'b0000, 0, e);
        chk("strb_zero_err", 32'(e), 32'd1);
`endif

        // Random traffic against the reference memory.
        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 2**AB - 1)) * 4;
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = a | (32'h1 << $urandom_range(AB + 2, 31));
            r = 1'($urandom_range(0, 1));
            txn(r, !r, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), e);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
